// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable watermarks, occupancy count, synchronous
// flush, sticky overflow/underflow flags and selectable first-word fall-through.
module sync_fifo_prog #(
  parameter int unsigned ASIZE       = 4,
  parameter int unsigned DSIZE       = 8,
  parameter string       FALLTHROUGH = "TRUE"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  input  logic             flush,
  input  logic             clr_err,
  input  logic [ASIZE:0]   afull_thresh,
  input  logic [ASIZE:0]   aempty_thresh,
  output logic [ASIZE:0]   wcount,
  output logic             wfull,
  output logic             awfull,
  output logic             rempty,
  output logic             arempty,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam int unsigned CW    = ASIZE + 1;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE-1:0] waddr;
  logic [ASIZE-1:0] raddr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             wa;
  logic             ra;

  // Accept decisions and next occupancy; flush overrides both requests.
  always_comb begin
    wa       = winc & ~wfull & ~flush;
    ra       = rinc & ~rempty & ~flush;
    cnt_next = cnt;
    if (flush) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + CW'(wa) - CW'(ra);
    end
  end

  always_ff @(posedge clk) begin
    if (wa) begin
      mem[waddr] <= wdata;
    end
  end

  // Pointers, occupancy and status flags, all derived from cnt_next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr   <= '0;
      raddr   <= '0;
      cnt     <= '0;
      wfull   <= 1'b0;
      awfull  <= 1'b0;
      rempty  <= 1'b1;
      arempty <= 1'b1;
    end else begin
      if (flush) begin
        waddr <= '0;
        raddr <= '0;
      end else begin
        if (wa) waddr <= waddr + ASIZE'(1);
        if (ra) raddr <= raddr + ASIZE'(1);
      end
      cnt     <= cnt_next;
      wfull   <= (cnt_next == CW'(DEPTH));
      rempty  <= (cnt_next == '0);
      awfull  <= (cnt_next >= afull_thresh);
      arempty <= (cnt_next <= aempty_thresh);
    end
  end

  assign wcount = cnt;

  // Sticky error flags; a same-cycle set beats clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc & wfull & ~flush) overflow <= 1'b1;
      else if (clr_err)          overflow <= 1'b0;
      if (rinc & rempty & ~flush) underflow <= 1'b1;
      else if (clr_err)           underflow <= 1'b0;
    end
  end

  generate
    if (FALLTHROUGH == "TRUE") begin : g_fwft
      assign rdata = rempty ? '0 : mem[raddr];
    end else begin : g_reg
      logic [DSIZE-1:0] rdata_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata_q <= '0;
        else if (ra) rdata_q <= mem[raddr];
      end
      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: an FWFT and a registered-read instance share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_sync_fifo_prog;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       winc = 1'b0;
  logic [7:0] wdata = '0;
  logic       rinc = 1'b0;
  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic [2:0] afull_thresh = 3'd3;
  logic [2:0] aempty_thresh = 3'd1;

  logic [7:0] rdata_f, rdata_r;
  logic [2:0] wcount_f, wcount_r;
  logic wfull_f, awfull_f, rempty_f, arempty_f, ovf_f, udf_f;
  logic wfull_r, awfull_r, rempty_r, arempty_r, ovf_r, udf_r;

  sync_fifo_prog #(.ASIZE(2), .DSIZE(8), .FALLTHROUGH("TRUE")) u_fwft (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata_f),
    .flush(flush), .clr_err(clr_err), .afull_thresh(afull_thresh),
    .aempty_thresh(aempty_thresh), .wcount(wcount_f), .wfull(wfull_f),
    .awfull(awfull_f), .rempty(rempty_f), .arempty(arempty_f),
    .overflow(ovf_f), .underflow(udf_f));

  sync_fifo_prog #(.ASIZE(2), .DSIZE(8), .FALLTHROUGH("FALSE")) u_reg (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata_r),
    .flush(flush), .clr_err(clr_err), .afull_thresh(afull_thresh),
    .aempty_thresh(aempty_thresh), .wcount(wcount_r), .wfull(wfull_r),
    .awfull(awfull_r), .rempty(rempty_r), .arempty(arempty_r),
    .overflow(ovf_r), .underflow(udf_r));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         ovf_m, udf_m, awf_m, aem_m;
  logic [7:0] rreg_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m = 0; udf_m = 0; awf_m = 0; aem_m = 1; rreg_m = '0;
  endtask

  task automatic model_edge();
    bit full, empty, wa, ra;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    wa = winc && !full && !flush;
    ra = rinc && !empty && !flush;
    if (winc && full && !flush) ovf_m = 1; else if (clr_err) ovf_m = 0;
    if (rinc && empty && !flush) udf_m = 1; else if (clr_err) udf_m = 0;
    if (flush) q.delete();
    else begin
      if (ra) rreg_m = q.pop_front();
      if (wa) q.push_back(wdata);
    end
    awf_m = (q.size() >= int'(afull_thresh));
    aem_m = (q.size() <= int'(aempty_thresh));
  endtask

  task automatic check_all();
    logic [7:0] fw_exp;
    fw_exp = (q.size() == 0) ? 8'h00 : q[0];
    check("f_wcount", 32'(wcount_f), 32'(q.size()));
    check("r_wcount", 32'(wcount_r), 32'(q.size()));
    check("f_wfull", 32'(wfull_f), 32'(q.size() == DEPTH));
    check("r_wfull", 32'(wfull_r), 32'(q.size() == DEPTH));
    check("f_rempty", 32'(rempty_f), 32'(q.size() == 0));
    check("r_rempty", 32'(rempty_r), 32'(q.size() == 0));
    check("f_awfull", 32'(awfull_f), 32'(awf_m));
    check("r_awfull", 32'(awfull_r), 32'(awf_m));
    check("f_arempty", 32'(arempty_f), 32'(aem_m));
    check("r_arempty", 32'(arempty_r), 32'(aem_m));
    check("f_overflow", 32'(ovf_f), 32'(ovf_m));
    check("r_overflow", 32'(ovf_r), 32'(ovf_m));
    check("f_underflow", 32'(udf_f), 32'(udf_m));
    check("r_underflow", 32'(udf_r), 32'(udf_m));
    check("f_rdata", 32'(rdata_f), 32'(fw_exp));
    check("r_rdata", 32'(rdata_r), 32'(rreg_m));
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit r,
                      input bit f = 0, input bit c = 0);
    winc = w; wdata = d; rinc = r; flush = f; clr_err = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Assert reset away from the clock edge, check outputs before any edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_rdata_r", 32'(rdata_r), 32'h0);
    check("rst_rempty", 32'(rempty_r), 32'h1);
    check_all();
    winc = 0; rinc = 0; flush = 0; clr_err = 0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    check("reset_rempty", 32'(rempty_f), 32'h1);
    check("reset_arempty", 32'(arempty_f), 32'h1);
    check("reset_wcount", 32'(wcount_f), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic FWFT write / read
    step(1, 8'hA1, 0);
    check("fwft_first_word", 32'(rdata_f), 32'hA1);
    check("fwft_not_empty", 32'(rempty_f), 32'h0);
    step(0, 8'h00, 1);
    check("read_to_empty", 32'(rempty_f), 32'h1);
    check("fwft_empty_zero", 32'(rdata_f), 32'h0);

    // Fill, overflow, drain; repeated for pointer wrap
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0);
      check("fill_wfull", 32'(wfull_f), 32'h1);
      check("fill_wcount", 32'(wcount_f), 32'h4);
      step(1, 8'h14, 0);
      check("fill_overflow", 32'(ovf_f), 32'h1);
      check("fill_reject", 32'(wcount_f), 32'h4);
      for (int i = 0; i < 4; i++) begin
        check("drain_fwft", 32'(rdata_f), 32'(8'h10 + i));
        step(0, 8'h00, 1);
        check("drain_reg", 32'(rdata_r), 32'(8'h10 + i));
      end
      step(0, 8'h00, 0, 0, 1);
    end

    // Simultaneous read/write at full, mid, empty
    for (int i = 0; i < 4; i++) step(1, 8'(8'h20 + i), 0);
    step(1, 8'h99, 1);
    check("both_at_full_cnt", 32'(wcount_f), 32'h3);
    check("both_at_full_ovf", 32'(ovf_f), 32'h1);
    step(0, 8'h00, 1);
    step(1, 8'h77, 1);
    check("both_mid_cnt", 32'(wcount_f), 32'h2);
    step(0, 8'h00, 1);
    check("both_mid_order0", 32'(rdata_r), 32'h23);
    step(0, 8'h00, 1);
    check("both_mid_order1", 32'(rdata_r), 32'h77);
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'h88, 1);
    check("both_empty_cnt", 32'(wcount_f), 32'h1);
    check("both_empty_udf", 32'(udf_f), 32'h1);
    step(0, 8'h00, 1);

    // Watermarks with afull=3, aempty=1
    step(1, 8'h31, 0);
    check("wm1_awfull", 32'(awfull_f), 32'h0);
    check("wm1_arempty", 32'(arempty_f), 32'h1);
    step(1, 8'h32, 0);
    check("wm2_arempty", 32'(arempty_f), 32'h0);
    check("wm2_awfull", 32'(awfull_f), 32'h0);
    step(1, 8'h33, 0);
    check("wm3_awfull", 32'(awfull_f), 32'h1);

    // Flush overrides winc/rinc and leaves error flags
    step(1, 8'hEE, 1, 1);
    check("flush_cnt", 32'(wcount_f), 32'h0);
    check("flush_rempty", 32'(rempty_f), 32'h1);
    check("flush_udf_kept", 32'(udf_f), 32'h1);
    check("flush_reg_hold", 32'(rdata_r), 32'h88);
    afull_thresh = 3'd0;
    step(0, 8'h00, 0);
    check("afull_zero", 32'(awfull_f), 32'h1);
    afull_thresh = 3'd3;
    step(0, 8'h00, 1, 0, 1);
    check("clr_vs_set", 32'(udf_f), 32'h1);
    step(0, 8'h00, 0, 0, 1);
    check("clr_alone", 32'(udf_f), 32'h0);

    // Registered read sequence
    step(1, 8'h55, 0);
    step(1, 8'h66, 0);
    step(0, 8'h00, 1);
    check("reg_first", 32'(rdata_r), 32'h55);
    step(0, 8'h00, 1);
    check("reg_second", 32'(rdata_r), 32'h66);
    step(0, 8'h00, 0);
    check("reg_hold", 32'(rdata_r), 32'h66);

    // Reset mid-stream
    step(1, 8'hC1, 0);
    step(1, 8'hC2, 1);
    async_reset();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 5) afull_thresh = 3'($urandom_range(0, 5));
      if ($urandom_range(0, 99) < 5) aempty_thresh = 3'($urandom_range(0, 5));
      step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6);
      if ($urandom_range(0, 999) < 3) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
